// File: rtl/cpu_step_controller.sv
// cpu_step_controller: generates the single-cycle MIPS datapath clock from
// realclock. Supports free-run at a divided rate, debounced single-step,
// external halt and a PC breakpoint, and counts retired cpu_clk cycles.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | cpu_clk held low; waiting for run_mode or a step press
// RUN   | free-running cpu_clk, DIV_COUNT cycles per half-period
// STEP  | one cpu_clk high pulse of DIV_COUNT cycles, then back to IDLE
// HALT  | stopped by halt_req or breakpoint; a step press steps past it
module cpu_step_controller #(
   parameter int DIV_COUNT       = 50000000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        realclock,
   input  logic        reset,
   input  logic        run_mode,
   input  logic        step_btn,
   input  logic        halt_req,
   input  logic        bp_enable,
   input  logic [31:0] bp_addr,
   input  logic [31:0] pc,
   output logic        cpu_clk,
   output logic        cpu_tick,
   output logic [1:0]  state,
   output logic        halted,
   output logic [31:0] cycle_count
);

   localparam int DIV_W = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
   localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      STEP = 2'b10,
      HALT = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic              cpu_clk_q, cpu_clk_d;
   logic              cpu_tick_q, cpu_tick_d;
   logic              halted_q, halted_d;
   logic [31:0]       cycle_count_q, cycle_count_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;

   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              deb_level_q, deb_level_d;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic              step_pulse_q, step_pulse_d;

   logic              div_term;
   logic              bp_hit;
   logic              rise;

   // Synchronize the pushbutton and accept a level change only after it has
   // been stable for DEBOUNCE_CYCLES samples; emit a pulse on each press.
   always_comb begin
      sync1_d      = step_btn;
      sync2_d      = sync1_q;
      deb_level_d  = deb_level_q;
      deb_cnt_d    = deb_cnt_q;
      step_pulse_d = 1'b0;
      if (sync2_q == deb_level_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         deb_cnt_d    = '0;
         deb_level_d  = ~deb_level_q;
         step_pulse_d = ~deb_level_q;
      end else begin
         deb_cnt_d = deb_cnt_q + 1'b1;
      end
   end

   // Next-state, divider and clock-edge decisions for the sequencer.
   always_comb begin
      state_d   = state_q;
      cpu_clk_d = cpu_clk_q;
      div_cnt_d = div_cnt_q;
      rise      = 1'b0;
      div_term  = (div_cnt_q == DIV_LAST);
      bp_hit    = bp_enable && (pc == bp_addr);

      case (state_q)
         IDLE: begin
            cpu_clk_d = 1'b0;
            if (run_mode && !halt_req) begin
               state_d   = RUN;
               div_cnt_d = '0;
            end else if (step_pulse_q) begin
               state_d   = STEP;
               div_cnt_d = '0;
               rise      = 1'b1;
            end
         end
         RUN: begin
            if (!div_term) begin
               div_cnt_d = div_cnt_q + 1'b1;
            end else begin
               div_cnt_d = '0;
               // Controls are only sampled at the end of a low phase so a
               // high phase always runs to completion.
               if (cpu_clk_q) begin
                  cpu_clk_d = 1'b0;
               end else if (halt_req) begin
                  state_d = HALT;
               end else if (bp_hit) begin
                  state_d = HALT;
               end else if (!run_mode) begin
                  state_d = IDLE;
               end else begin
                  rise = 1'b1;
               end
            end
         end
         STEP: begin
            if (div_term) begin
               div_cnt_d = '0;
               cpu_clk_d = 1'b0;
               state_d   = IDLE;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         HALT: begin
            cpu_clk_d = 1'b0;
            if (step_pulse_q) begin
               state_d   = STEP;
               div_cnt_d = '0;
               rise      = 1'b1;
            end else if (!run_mode) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            cpu_clk_d = 1'b0;
         end
      endcase

      if (rise) begin
         cpu_clk_d = 1'b1;
      end
      cpu_tick_d    = rise;
      cycle_count_d = cycle_count_q + 32'(rise);
      halted_d      = (state_d == HALT);
   end

   // Sequencer registers; reset also forces cpu_clk low mid high-phase.
   always_ff @(posedge realclock) begin
      if (reset) begin
         state_q       <= IDLE;
         cpu_clk_q     <= 1'b0;
         cpu_tick_q    <= 1'b0;
         halted_q      <= 1'b0;
         cycle_count_q <= '0;
         div_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         cpu_clk_q     <= cpu_clk_d;
         cpu_tick_q    <= cpu_tick_d;
         halted_q      <= halted_d;
         cycle_count_q <= cycle_count_d;
         div_cnt_q     <= div_cnt_d;
      end
   end

   // Pushbutton synchronizer and debounce registers.
   always_ff @(posedge realclock) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         deb_level_q  <= 1'b0;
         deb_cnt_q    <= '0;
         step_pulse_q <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         deb_level_q  <= deb_level_d;
         deb_cnt_q    <= deb_cnt_d;
         step_pulse_q <= step_pulse_d;
      end
   end

   assign cpu_clk     = cpu_clk_q;
   assign cpu_tick    = cpu_tick_q;
   assign state       = state_q;
   assign halted      = halted_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with DIV_COUNT=4, DEBOUNCE_CYCLES=3.
// A tiny processor model advances pc by 4 on every cpu_clk rise.
module tb_cpu_step_controller;

   logic        realclock = 1'b0;
   logic        reset;
   logic        run_mode;
   logic        step_btn;
   logic        halt_req;
   logic        bp_enable;
   logic [31:0] bp_addr;
   logic [31:0] pc;
   logic        cpu_clk;
   logic        cpu_tick;
   logic [1:0]  state;
   logic        halted;
   logic [31:0] cycle_count;

   logic [31:0] rise_cnt = 32'd0;
   logic [31:0] pc_base  = 32'd0;

   int n_cmp = 0;
   int n_bad = 0;
   int hi_cyc, tick_cnt, step_cyc;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_STEP = 2'b10;
   localparam logic [1:0] S_HALT = 2'b11;

   cpu_step_controller #(
      .DIV_COUNT       (4),
      .DEBOUNCE_CYCLES (3)
   ) dut (
      .realclock   (realclock),
      .reset       (reset),
      .run_mode    (run_mode),
      .step_btn    (step_btn),
      .halt_req    (halt_req),
      .bp_enable   (bp_enable),
      .bp_addr     (bp_addr),
      .pc          (pc),
      .cpu_clk     (cpu_clk),
      .cpu_tick    (cpu_tick),
      .state       (state),
      .halted      (halted),
      .cycle_count (cycle_count)
   );

   always #5 realclock = ~realclock;

   // Processor model: pc advances one word per retired cpu_clk rise.
   always @(posedge cpu_clk) rise_cnt <= rise_cnt + 32'd1;
   assign pc = (rise_cnt - pc_base) << 2;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge realclock);
      #1;
   endtask

   task automatic clr_mon();
      hi_cyc   = 0;
      tick_cnt = 0;
      step_cyc = 0;
   endtask

   task automatic run_mon(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         if (cpu_clk)          hi_cyc++;
         if (cpu_tick)         tick_cnt++;
         if (state == S_STEP)  step_cyc++;
      end
   endtask

   task automatic wait_state(input string tag, input logic [1:0] exp, input int budget);
      int n = 0;
      while (state !== exp && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, {30'd0, state}, {30'd0, exp});
   endtask

   task automatic wait_tick(input string tag, input int budget);
      int n = 0;
      while (cpu_tick !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, {31'd0, cpu_tick}, 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      run_mode  = 1'b0;
      step_btn  = 1'b0;
      halt_req  = 1'b0;
      bp_enable = 1'b0;
      bp_addr   = 32'd0;
      tick();
      tick();
      check_eq("rst_state", {30'd0, state}, {30'd0, S_IDLE});
      check_eq("rst_clk", {31'd0, cpu_clk}, 32'd0);
      check_eq("rst_tick", {31'd0, cpu_tick}, 32'd0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      check_eq("rst_count", cycle_count, 32'd0);
      reset = 1'b0;

      // Idle with nothing requested.
      clr_mon();
      run_mon(20);
      check_eq("idle_state", {30'd0, state}, {30'd0, S_IDLE});
      check_eq("idle_clk", {31'd0, cpu_clk}, 32'd0);
      check_eq("idle_count", cycle_count, 32'd0);
      check_eq("idle_ticks", tick_cnt, 32'd0);

      // Free run: rise 4 cycles after entry, then 4 high / 4 low.
      run_mode = 1'b1;
      tick();
      check_eq("run_entry", {30'd0, state}, {30'd0, S_RUN});
      check_eq("run_entry_clk", {31'd0, cpu_clk}, 32'd0);
      for (int k = 1; k <= 32; k++) begin
         tick();
         check_eq($sformatf("run_clk_k%0d", k), {31'd0, cpu_clk}, ((k / 4) % 2 == 1) ? 32'd1 : 32'd0);
         check_eq($sformatf("run_tick_k%0d", k), {31'd0, cpu_tick}, (k % 8 == 4) ? 32'd1 : 32'd0);
      end
      check_eq("run_count", cycle_count, 32'd4);
      run_mode = 1'b0;
      wait_state("run_to_idle", S_IDLE, 20);
      check_eq("run_stop_count", cycle_count, 32'd4);
      check_eq("run_stop_clk", {31'd0, cpu_clk}, 32'd0);

      // Single step from a 10-cycle press.
      clr_mon();
      step_btn = 1'b1;
      run_mon(10);
      step_btn = 1'b0;
      run_mon(20);
      check_eq("step_hi_cyc", hi_cyc, 32'd4);
      check_eq("step_ticks", tick_cnt, 32'd1);
      check_eq("step_state_cyc", step_cyc, 32'd4);
      check_eq("step_end_state", {30'd0, state}, {30'd0, S_IDLE});
      check_eq("step_count", cycle_count, 32'd5);

      // A 2-cycle glitch must be rejected.
      clr_mon();
      step_btn = 1'b1;
      run_mon(2);
      step_btn = 1'b0;
      run_mon(20);
      check_eq("glitch_ticks", tick_cnt, 32'd0);
      check_eq("glitch_count", cycle_count, 32'd5);

      // Holding the button gives exactly one step.
      clr_mon();
      step_btn = 1'b1;
      run_mon(1000);
      step_btn = 1'b0;
      run_mon(20);
      check_eq("hold_ticks", tick_cnt, 32'd1);
      check_eq("hold_hi_cyc", hi_cyc, 32'd4);
      check_eq("hold_count", cycle_count, 32'd6);

      // Breakpoint at 0x0C: halt with pc=0x0C before executing it.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("bp_rst_count", cycle_count, 32'd0);
      pc_base   = rise_cnt;
      bp_enable = 1'b1;
      bp_addr   = 32'h0000_000C;
      run_mode  = 1'b1;
      wait_state("bp_halt", S_HALT, 100);
      check_eq("bp_halted", {31'd0, halted}, 32'd1);
      check_eq("bp_clk", {31'd0, cpu_clk}, 32'd0);
      check_eq("bp_count", cycle_count, 32'd3);
      check_eq("bp_pc", pc, 32'h0000_000C);
      clr_mon();
      run_mon(5);
      check_eq("bp_hold_state", {30'd0, state}, {30'd0, S_HALT});
      check_eq("bp_hold_ticks", tick_cnt, 32'd0);

      // Step past the breakpoint, then resume running.
      step_btn = 1'b1;
      wait_state("bp_step", S_STEP, 20);
      check_eq("bp_step_tick", {31'd0, cpu_tick}, 32'd1);
      step_btn = 1'b0;
      wait_state("bp_step_idle", S_IDLE, 20);
      check_eq("bp_step_pc", pc, 32'h0000_0010);
      check_eq("bp_step_count", cycle_count, 32'd4);
      tick();
      check_eq("bp_resume", {30'd0, state}, {30'd0, S_RUN});

      // halt_req raised at a rise: high phase completes, halt at low terminal.
      wait_tick("halt_rise", 40);
      halt_req = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check_eq($sformatf("halt_clk_k%0d", k), {31'd0, cpu_clk}, (k < 4) ? 32'd1 : 32'd0);
         if (k == 7) check_eq("halt_not_yet", {30'd0, state}, {30'd0, S_RUN});
      end
      check_eq("halt_state", {30'd0, state}, {30'd0, S_HALT});
      check_eq("halt_halted", {31'd0, halted}, 32'd1);
      halt_req = 1'b0;
      run_mode = 1'b0;
      tick();
      check_eq("halt_release", {30'd0, state}, {30'd0, S_IDLE});

      // Reset during the second cycle of a step high phase.
      step_btn = 1'b1;
      wait_state("rst_step", S_STEP, 20);
      tick();
      check_eq("rst_step_hi", {31'd0, cpu_clk}, 32'd1);
      reset    = 1'b1;
      step_btn = 1'b0;
      tick();
      check_eq("rst_mid_clk", {31'd0, cpu_clk}, 32'd0);
      check_eq("rst_mid_state", {30'd0, state}, {30'd0, S_IDLE});
      check_eq("rst_mid_count", cycle_count, 32'd0);
      reset = 1'b0;
      tick();

      // Counter wrap: preset to all ones, one rise returns it to zero.
      force dut.cycle_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.cycle_count_q;
      step_btn = 1'b1;
      wait_state("wrap_step", S_STEP, 20);
      check_eq("wrap_count", cycle_count, 32'd0);
      check_eq("wrap_tick", {31'd0, cpu_tick}, 32'd1);
      step_btn = 1'b0;
      wait_state("wrap_idle", S_IDLE, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
